// File: rtl/mpeg2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mpeg2_pkg
// Description : Shared definitions for the MPEG2 result packer slice:
//               result-record field positions, the packer state encoding,
//               the FIFO entry layout and a stream-word lane selector.
// Revision    : 1.0 - initial release
// ============================================================================
package mpeg2_pkg;

  localparam int RESULT_WIDTH   = 336;
  localparam int FLAG_VALID_BIT = 0;
  localparam int FLAG_STOP_BIT  = 1;
  localparam int PAYLOAD_LSB    = 80;
  localparam int PAYLOAD_WIDTH  = 256;
  localparam int BEAT_WIDTH     = 64;
  localparam int BEATS_PER_WORD = PAYLOAD_WIDTH / BEAT_WIDTH;
  localparam int BYTES_PER_WORD = PAYLOAD_WIDTH / 8;
  localparam int ENTRY_WIDTH    = PAYLOAD_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BEAT  = 2'd2,
    TRAIL = 2'd3
  } packer_state_e;

  // tag=1 marks a stop record; its payload field carries no data.
  typedef struct packed {
    logic                     tag;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } fifo_entry_t;

  // Lane 0 is the least significant 64 bits of the stream word.
  function automatic logic [BEAT_WIDTH-1:0] word_lane(
    input logic [PAYLOAD_WIDTH-1:0] word,
    input logic [1:0]               lane
  );
    return word[lane*BEAT_WIDTH +: BEAT_WIDTH];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpeg2_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mpeg2_result_fifo
// Description : Synchronous FIFO with registered read data. A pop loads the
//               head entry into rd_data on the clock edge; rd_data then holds
//               until the next pop. A push while full is taken only when a
//               pop happens in the same cycle.
// Ports       : clk, rstn (async, active-low), clear (sync flush)
//               push/push_data  - write strobe and entry
//               pop             - read strobe, ignored when empty
//               rd_data         - registered head entry
//               empty/full      - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module mpeg2_result_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear && (!full || do_pop);
  assign rd_data = rd_data_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_data_d = mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mpeg2_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : mpeg2_result_packer
// Description : Buffers MPEG2 encoder result records in a FIFO and serialises
//               each 256-bit stream word into four 64-bit beats (LSW first)
//               on a ready/valid master port. A stop record produces a
//               trailer beat (m_last=1) carrying the sequence byte count.
// Ports       : clk, rstn (async, active-low), clear (sync soft flush)
//               in_data/in_valid            - result records, no backpressure
//               m_data/m_valid/m_last/m_ready - output beat stream
//               overflow                    - sticky record-drop flag
//               drop_count/beat_count       - statistics counters
// Build option: MPEG2_PACKER_STATS_EN enables drop_count and beat_count;
//               without it both outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mpeg2_result_packer #(
  parameter int RESULT_WIDTH = 336,
  parameter int OUT_WIDTH    = 64,
  parameter int DEPTH        = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clear,
  input  logic [RESULT_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic [OUT_WIDTH-1:0]    m_data,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic                    overflow,
  output logic [CNT_WIDTH-1:0]    drop_count,
  output logic [CNT_WIDTH-1:0]    beat_count
);

  import mpeg2_pkg::*;

  // --------------------------------------------------------------------------
  // Record classification and FIFO
  // --------------------------------------------------------------------------
  fifo_entry_t rec_entry;
  fifo_entry_t fifo_rd;
  logic        rec_valid;
  logic        rec_drop;
  logic        fifo_pop;
  logic        fifo_empty;
  logic        fifo_full;
  logic        unused_in_bits;

  // clear wins over a record arriving in the same cycle.
  assign rec_valid = in_valid && in_data[FLAG_VALID_BIT] && !clear;
  assign rec_drop  = rec_valid && fifo_full && !fifo_pop;
  assign unused_in_bits = ^in_data[PAYLOAD_LSB-1:FLAG_STOP_BIT+1];

  always_comb begin
    rec_entry.tag     = in_data[FLAG_STOP_BIT];
    rec_entry.payload = in_data[FLAG_STOP_BIT] ? '0
                                               : in_data[PAYLOAD_LSB +: PAYLOAD_WIDTH];
  end

  mpeg2_result_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .push      (rec_valid),
    .push_data (rec_entry),
    .pop       (fifo_pop),
    .rd_data   (fifo_rd),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // --------------------------------------------------------------------------
  // Output state machine
  // --------------------------------------------------------------------------
  packer_state_e            state_q,    state_d;
  logic [1:0]               idx_q,      idx_d;
  logic [PAYLOAD_WIDTH-1:0] payload_q,  payload_d;
  logic [CNT_WIDTH-1:0]     byte_cnt_q, byte_cnt_d;
  logic [OUT_WIDTH-1:0]     m_data_q,   m_data_d;
  logic                     m_valid_q,  m_valid_d;
  logic                     m_last_q,   m_last_d;
  logic                     overflow_q, overflow_d;
  logic [1:0]               idx_next;

  assign idx_next = idx_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    payload_d  = payload_q;
    byte_cnt_d = byte_cnt_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    overflow_d = overflow_q;
    fifo_pop   = 1'b0;

    if (clear) begin
      // Abandon any beat in flight; the FIFO flushes itself on clear.
      state_d    = IDLE;
      idx_d      = '0;
      byte_cnt_d = '0;
      m_data_d   = '0;
      m_valid_d  = 1'b0;
      m_last_d   = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (rec_drop) begin
        overflow_d = 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = LOAD;
          end
        end

        // fifo_rd holds the entry popped on the previous edge.
        LOAD: begin
          m_valid_d = 1'b1;
          if (fifo_rd.tag) begin
            m_data_d = OUT_WIDTH'(byte_cnt_q);
            m_last_d = 1'b1;
            state_d  = TRAIL;
          end else begin
            payload_d = fifo_rd.payload;
            idx_d     = '0;
            m_data_d  = word_lane(fifo_rd.payload, 2'd0);
            m_last_d  = 1'b0;
            state_d   = BEAT;
          end
        end

        BEAT: begin
          if (m_ready) begin
            if (idx_q == 2'(BEATS_PER_WORD - 1)) begin
              m_valid_d  = 1'b0;
              byte_cnt_d = byte_cnt_q + CNT_WIDTH'(BYTES_PER_WORD);
              state_d    = IDLE;
            end else begin
              idx_d    = idx_next;
              m_data_d = word_lane(payload_q, idx_next);
            end
          end
        end

        TRAIL: begin
          if (m_ready) begin
            m_valid_d  = 1'b0;
            m_last_d   = 1'b0;
            byte_cnt_d = '0;
            state_d    = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      payload_q  <= '0;
      byte_cnt_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      payload_q  <= payload_d;
      byte_cnt_q <= byte_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      overflow_q <= overflow_d;
    end
  end

  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign overflow = overflow_q;

  // --------------------------------------------------------------------------
  // Statistics counters
  // --------------------------------------------------------------------------
`ifdef MPEG2_PACKER_STATS_EN
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic [CNT_WIDTH-1:0] beat_count_q, beat_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    beat_count_d = beat_count_q;
    if (clear) begin
      drop_count_d = '0;
      beat_count_d = '0;
    end else begin
      if (rec_drop) begin
        drop_count_d = drop_count_q + 1'b1;
      end
      if (m_valid_q && m_ready) begin
        beat_count_d = beat_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_count_q <= '0;
      beat_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign drop_count = drop_count_q;
  assign beat_count = beat_count_q;
`else
  assign drop_count = '0;
  assign beat_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mpeg2_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mpeg2_result_packer
// Description : Self-checking bench for mpeg2_result_packer (DEPTH=4).
//               Table of single-record vectors plus hand-written sequences
//               for stall, overflow, clear and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mpeg2_result_packer;

  localparam int RW    = 336;
  localparam int OW    = 64;
  localparam int CW    = 32;
  localparam int DEPTH = 4;
`ifdef MPEG2_PACKER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic          clk      = 1'b0;
  logic          rstn     = 1'b0;
  logic          clear    = 1'b0;
  logic          in_valid = 1'b0;
  logic          m_ready  = 1'b0;
  logic [RW-1:0] in_data  = '0;
  logic [OW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          overflow;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] beat_count;

  always #5 clk = ~clk;

  mpeg2_result_packer #(
    .RESULT_WIDTH (RW),
    .OUT_WIDTH    (OW),
    .DEPTH        (DEPTH),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .overflow   (overflow),
    .drop_count (drop_count),
    .beat_count (beat_count)
  );

  int          checks = 0;
  int          fails  = 0;
  logic [OW:0] cap_q[$];
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_clear = 1'b0;
  logic        prev_last  = 1'b0;
  logic [OW-1:0] prev_data = '0;
  logic        seen_valid = 1'b0;

  typedef struct {
    logic         vbit;
    logic         stop;
    logic [255:0] payload;
    int           nbeats;
    logic [63:0]  trailer;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lane(input logic [255:0] w, input int i);
    return w[64*i +: 64];
  endfunction

  // Word whose lane j reads {w, j} so every beat is distinguishable.
  function automatic logic [255:0] mkword(input int w);
    logic [255:0] r;
    for (int j = 0; j < 4; j++) r[64*j +: 64] = {32'(w), 32'(j)};
    return r;
  endfunction

  // One clock: sample at the falling edge, then return just after the
  // rising edge so the caller can drive the next cycle's inputs.
  task automatic step();
    @(negedge clk);
    seen_valid = m_valid;
    if (prev_valid && !prev_ready && !prev_clear && rstn) begin
      check("hold_valid", 64'(m_valid), 64'd1);
      check("hold_data",  m_data, prev_data);
      check("hold_last",  64'(m_last), 64'(prev_last));
    end
    if (m_valid && m_ready) cap_q.push_back({m_last, m_data});
    prev_valid = m_valid;
    prev_ready = m_ready;
    prev_clear = clear;
    prev_data  = m_data;
    prev_last  = m_last;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic vbit, input logic stop, input logic [255:0] pl);
    in_data          = '0;
    in_data[335:80]  = pl;
    in_data[1]       = stop;
    in_data[0]       = vbit;
    in_valid         = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_beats(input int n, input string name);
    int budget = 0;
    while (cap_q.size() < n && budget < 40) begin
      step();
      budget++;
    end
    check(name, 64'(cap_q.size() >= n), 64'd1);
  endtask

  initial begin
    // ---------------- table: one record per vector, m_ready held high
    vecs[0] = '{1'b1, 1'b0, {64'h3, 64'h2, 64'h1, 64'h0}, 4, 64'd0};
    vecs[1] = '{1'b1, 1'b1, 256'h0, 1, 64'd32};
    vecs[2] = '{1'b1, 1'b0, {64'hdead_beef_0000_0004, 64'h1234_5678_9abc_def0,
                             64'hffff_ffff_ffff_ffff, 64'h8000_0000_0000_0001}, 4, 64'd0};
    vecs[3] = '{1'b1, 1'b0, {64'h0123_4567_89ab_cdef, 64'h5555_aaaa_5555_aaaa,
                             64'h0000_0000_ffff_0000, 64'h7777_0000_0000_7777}, 4, 64'd0};
    vecs[4] = '{1'b1, 1'b1, 256'h0, 1, 64'd64};
    vecs[5] = '{1'b1, 1'b1, 256'h0, 1, 64'd0};
    vecs[6] = '{1'b0, 1'b0, {4{64'hbad0_bad0_bad0_bad0}}, 0, 64'd0};

    // ---------------- reset state
    #2;
    check("rst_m_valid",    64'(m_valid),  64'd0);
    check("rst_m_last",     64'(m_last),   64'd0);
    check("rst_m_data",     m_data,        64'd0);
    check("rst_overflow",   64'(overflow), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_beat_count", 64'(beat_count), 64'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    m_ready = 1'b1;
    step();

    for (int v = 0; v < 7; v++) begin
      int first;
      first = -1;
      cap_q.delete();
      send(vecs[v].vbit, vecs[v].stop, vecs[v].payload);
      for (int c = 1; c <= 30; c++) begin
        step();
        if (first < 0 && seen_valid) first = c;
      end
      check($sformatf("v%0d_nbeats", v), 64'(cap_q.size()), 64'(vecs[v].nbeats));
      // Push at edge k -> m_valid after edge k+2 -> third falling-edge sample.
      if (vecs[v].nbeats > 0) check($sformatf("v%0d_latency", v), 64'(first), 64'd3);
      for (int i = 0; i < cap_q.size() && i < vecs[v].nbeats; i++) begin
        logic [63:0] exp_d;
        exp_d = vecs[v].stop ? vecs[v].trailer : lane(vecs[v].payload, i);
        check($sformatf("v%0d_b%0d_data", v, i), cap_q[i][63:0], exp_d);
        check($sformatf("v%0d_b%0d_last", v, i), 64'(cap_q[i][64]), 64'(vecs[v].stop));
      end
    end
    // 4+1+4+4+1+1 accepted beats so far.
    check("table_beat_count", 64'(beat_count), STATS ? 64'd15 : 64'd0);

    // ---------------- stall for 5 cycles after the first beat
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_beat_count", 64'(beat_count), 64'd0);
    cap_q.delete();
    send(1'b1, 1'b0, mkword(1));
    wait_beats(1, "stall_first_beat");
    m_ready = 1'b0;
    repeat (5) step();
    check("stall_no_beats", 64'(cap_q.size()), 64'd1);
    m_ready = 1'b1;
    repeat (20) step();
    check("stall_nbeats", 64'(cap_q.size()), 64'd4);
    for (int i = 0; i < cap_q.size() && i < 4; i++)
      check($sformatf("stall_b%0d", i), cap_q[i][63:0], lane(mkword(1), i));
    check("stall_beat_count", 64'(beat_count), STATS ? 64'd4 : 64'd0);

    // ---------------- overflow with m_ready low
    // Word 0 is popped into the output stage, words 1..4 fill the FIFO,
    // word 5 is dropped: five words (20 beats) survive.
    cap_q.delete();
    m_ready = 1'b0;
    for (int w = 0; w < 6; w++) begin
      send(1'b1, 1'b0, mkword(16 + w));
      step();
    end
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drop_count", 64'(drop_count), STATS ? 64'd1 : 64'd0);
    m_ready = 1'b1;
    repeat (100) step();
    check("ovf_nbeats", 64'(cap_q.size()), 64'd20);
    if (cap_q.size() == 20) begin
      check("ovf_first", cap_q[0][63:0],  lane(mkword(16), 0));
      check("ovf_w4b0",  cap_q[16][63:0], lane(mkword(20), 0));
      check("ovf_last",  cap_q[19][63:0], lane(mkword(20), 3));
    end

    // ---------------- clear during beat idx=2 with 3 entries queued
    cap_q.delete();
    m_ready = 1'b0;
    for (int w = 0; w < 4; w++) begin
      send(1'b1, 1'b0, mkword(8 + w));
      step();
    end
    m_ready = 1'b1;
    wait_beats(2, "clr_two_beats");
    m_ready         = 1'b0;
    clear           = 1'b1;
    in_valid        = 1'b1;
    in_data         = '0;
    in_data[335:80] = mkword(99);
    in_data[0]      = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    check("clr_m_valid",    64'(m_valid),    64'd0);
    check("clr_overflow",   64'(overflow),   64'd0);
    check("clr_drop_count", 64'(drop_count), 64'd0);
    m_ready = 1'b1;
    repeat (40) step();
    check("clr_no_more_beats", 64'(cap_q.size()), 64'd2);
    if (cap_q.size() == 2) check("clr_b1", cap_q[1][63:0], lane(mkword(8), 1));

    // ---------------- asynchronous reset mid-burst
    cap_q.delete();
    send(1'b1, 1'b0, mkword(3));
    wait_beats(1, "arst_first_beat");
    #2 rstn = 1'b0;
    #1;
    check("arst_m_valid", 64'(m_valid), 64'd0);
    check("arst_m_data",  m_data,       64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    prev_valid = 1'b0;
    repeat (10) step();
    check("arst_no_more_beats", 64'(cap_q.size()), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
